// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: single-master bus fabric that decodes the master address
// onto SLAVES slave ports, keeps at most one read outstanding, times out
// silent or stalling slaves and reports unmapped/odd accesses as bus errors.
module soc_bus_fabric #(
  parameter int                   SLAVES     = 4,
  parameter int                   DATA_W     = 32,
  parameter int                   TIMEOUT    = 255,
  parameter logic [SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES*32-1:0] SLAVE_MASK = '0,
  parameter logic [DATA_W-1:0]    ERR_DATA   = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              address,
  input  logic                     read,
  input  logic                     write,
  output logic                     waitRequest,
  output logic                     readValid,
  output logic [DATA_W-1:0]        dataIn,
  output logic [SLAVES-1:0]        slaveRead,
  output logic [SLAVES-1:0]        slaveWrite,
  input  logic [SLAVES-1:0]        slaveWaitRequest,
  input  logic [SLAVES-1:0]        slaveValid,
  input  logic [SLAVES*DATA_W-1:0] slaveData,
  output logic                     busError,
  output logic [31:0]              errorAddress,
  output logic [7:0]               errorCount
);

  localparam int          IDX_W     = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, PENDING, ERRRET} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        timer_q, timer_d;
  logic               read_valid_q, read_valid_d;
  logic [DATA_W-1:0]  data_in_q, data_in_d;
  logic               bus_error_q, bus_error_d;
  logic [31:0]        error_address_q, error_address_d;
  logic [7:0]         error_count_q, error_count_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               wait_c;
  logic [SLAVES-1:0]  slave_read_c, slave_write_c;
  logic               log_err;
  logic [31:0]        err_src;
  logic [15:0]        timer_inc;
  logic               timed_out;

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if ((address & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Next-state, slave strobes, stall and error bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d         = state_q;
    idx_d           = idx_q;
    addr_d          = addr_q;
    timer_d         = timer_q;
    read_valid_d    = 1'b0;
    data_in_d       = data_in_q;
    bus_error_d     = 1'b0;
    error_address_d = error_address_q;
    error_count_d   = error_count_q;
    wait_c          = 1'b0;
    slave_read_c    = '0;
    slave_write_c   = '0;
    log_err         = 1'b0;
    err_src         = address;
    timer_inc       = timer_q + 16'd1;
    timed_out       = (timer_inc == TIMEOUT_C);

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (read) begin
          // A read wins over a simultaneous write; the write is reported as an error.
          if (!hit) begin
            state_d      = ERRRET;
            read_valid_d = 1'b1;
            data_in_d    = ERR_DATA;
            log_err      = 1'b1;
          end else begin
            slave_read_c[hit_idx] = 1'b1;
            if (slaveWaitRequest[hit_idx] && !timed_out) begin
              wait_c  = 1'b1;
              timer_d = timer_inc;
            end else if (slaveWaitRequest[hit_idx]) begin
              // Stalled too long: release the master and answer with an error.
              state_d      = ERRRET;
              read_valid_d = 1'b1;
              data_in_d    = ERR_DATA;
              log_err      = 1'b1;
            end else begin
              state_d = PENDING;
              idx_d   = hit_idx;
              addr_d  = address;
              log_err = write;
            end
          end
        end else if (write) begin
          if (hit) begin
            slave_write_c[hit_idx] = 1'b1;
            wait_c                 = slaveWaitRequest[hit_idx];
          end else begin
            log_err = 1'b1;
          end
        end
      end

      PENDING: begin
        wait_c = read | write;
        if (slaveValid[idx_q]) begin
          state_d      = IDLE;
          read_valid_d = 1'b1;
          data_in_d    = slaveData[idx_q*DATA_W +: DATA_W];
          timer_d      = '0;
        end else if (timed_out) begin
          state_d      = ERRRET;
          read_valid_d = 1'b1;
          data_in_d    = ERR_DATA;
          log_err      = 1'b1;
          err_src      = addr_q;
          timer_d      = '0;
        end else begin
          timer_d = timer_inc;
        end
      end

      ERRRET: begin
        // Error response is on the bus this cycle; hold off new requests.
        wait_c  = read | write;
        state_d = IDLE;
        timer_d = '0;
      end

      default: state_d = IDLE;
    endcase

    if (log_err) begin
      bus_error_d     = 1'b1;
      error_address_d = err_src;
      if (error_count_q != 8'hFF) error_count_d = error_count_q + 8'd1;
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      addr_q          <= '0;
      timer_q         <= '0;
      read_valid_q    <= 1'b0;
      data_in_q       <= '0;
      bus_error_q     <= 1'b0;
      error_address_q <= '0;
      error_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      addr_q          <= addr_d;
      timer_q         <= timer_d;
      read_valid_q    <= read_valid_d;
      data_in_q       <= data_in_d;
      bus_error_q     <= bus_error_d;
      error_address_q <= error_address_d;
      error_count_q   <= error_count_d;
    end
  end

  // Reset masks every strobe and pulse, including in the cycle it is raised.
  assign waitRequest  = reset & wait_c;
  assign slaveRead    = reset ? slave_read_c  : '0;
  assign slaveWrite   = reset ? slave_write_c : '0;
  assign readValid    = reset & read_valid_q;
  assign busError     = reset & bus_error_q;
  assign dataIn       = data_in_q;
  assign errorAddress = error_address_q;
  assign errorCount   = error_count_q;

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SLAVES, 4, number of slave ports, 1..16.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles a read may stay outstanding or stalled, 2..65535.
- SLAVE_BASE, all-zero, packed SLAVES x 32 base addresses.
- SLAVE_MASK, all-zero, packed SLAVES x 32 decode masks.
- ERR_DATA, 32'hDEAD_BEEF, data returned on error.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous active-low reset: the block resets when reset is 0 at a rising clk edge.
- address, in, 32, master address.
- read, in, 1, master read strobe.
- write, in, 1, master write strobe.
- waitRequest, out, 1, stall to master.
- readValid, out, 1, read data valid to master.
- dataIn, out, DATA_W, read data to master.
- slaveRead, out, SLAVES, per-slave read strobe.
- slaveWrite, out, SLAVES, per-slave write strobe.
- slaveWaitRequest, in, SLAVES, per-slave stall.
- slaveValid, in, SLAVES, per-slave read valid.
- slaveData, in, SLAVES x DATA_W, per-slave read data.
- busError, out, 1, one-cycle error pulse.
- errorAddress, out, 32, address of the last errored access.
- errorCount, out, 8, saturating error count.

Function
REQ-003 Decode SHALL be combinational: slave i hits when (address & SLAVE_MASK[i]) == SLAVE_BASE[i]; on multiple hits the lowest index wins; no hit means unmapped.
REQ-004 The FSM SHALL have three states: IDLE, PENDING (one read outstanding) and ERRRET (error response owed); there is at most one outstanding read.
REQ-005 In IDLE, a read to slave i SHALL drive slaveRead[i]=1 combinationally; waitRequest = slaveWaitRequest[i].
REQ-006 Read acceptance: when read=1 and slaveWaitRequest[i]=0, the fabric SHALL register index i, clear the timer and enter PENDING.
REQ-007 In PENDING, waitRequest SHALL be 1 for any read or write, and all slave strobes SHALL be 0.
REQ-008 In PENDING, slaveValid[idx]=1 SHALL register slaveData[idx] and give readValid=1 with dataIn = that data on the next cycle; the FSM returns to IDLE on the same edge, so a new request is accepted in the cycle readValid is high.
REQ-009 slaveValid from any non-selected slave, or from any slave in IDLE, SHALL be ignored.
REQ-010 Writes in IDLE to slave i SHALL drive slaveWrite[i]=1 with waitRequest = slaveWaitRequest[i]; writes are posted and produce no readValid.
REQ-011 An unmapped read SHALL be accepted without stall and enter ERRRET; the next cycle gives readValid=1, dataIn=ERR_DATA and busError=1, then the FSM goes to IDLE.
REQ-012 An unmapped write SHALL be accepted without stall and dropped, with busError=1 on the next cycle.
REQ-013 read and write both high in IDLE SHALL be treated as the read; the write is dropped and busError pulses one cycle after acceptance.
REQ-014 A 16-bit timer SHALL count cycles while in PENDING or while a read is stalled by slaveWaitRequest.
  - When the timer reaches TIMEOUT, the stall is released (waitRequest=0 that cycle, slaveRead deasserted next cycle) and the error response of REQ-011 follows.
  - A late slaveValid after a timeout is ignored per REQ-009.
REQ-015 On every busError, errorAddress SHALL capture the offending address and errorCount SHALL increment, saturating at 255.
REQ-016 readValid, busError and the slave strobes SHALL never be asserted in the same cycle as an active reset.

Reset
REQ-017 With reset=0 at a clk edge, the block SHALL take these values:
- FSM IDLE, timer 0.
- readValid=0, dataIn=0, busError=0.
- errorAddress=0, errorCount=0.
REQ-018 A reset asserted in PENDING SHALL abort the read; no readValid is produced afterwards for it.
REQ-019 During reset, waitRequest, slaveRead and slaveWrite SHALL be 0.

Verification
Bench configuration: SLAVES=2, TIMEOUT=8, BASE0=0x0000_0000 with MASK0=0xFFFF_C000, BASE1=0x8000_0000 with MASK1=0xFFFF_FFF0.

REQ-020 Read from 0x0000_0010, slave0 slaveValid 3 cycles after acceptance with data 0x1234_5678 -> readValid=1 and dataIn=0x1234_5678 exactly one cycle later; slaveRead[0] high for 1 cycle.
REQ-021 Write to 0x8000_0004 with slaveWaitRequest[1] high for 2 cycles -> waitRequest high for 2 cycles, slaveWrite[1] high for 3 cycles, no readValid.
REQ-022 Read from unmapped 0x4000_0000 -> next cycle readValid=1, dataIn=0xDEAD_BEEF, busError=1, errorAddress=0x4000_0000, errorCount=1.
REQ-023 Read to slave1 that is never answered -> readValid with 0xDEAD_BEEF and busError at cycle 8 after acceptance; an injected slaveValid[1] at cycle 10 is ignored.
REQ-024 Drive 300 unmapped writes -> errorCount saturates at 255.
REQ-025 Reset pulsed in PENDING, then slaveValid[0] -> no readValid, FSM in IDLE, counters 0.
